// File: rtl/ad7895_emulator_if.sv
// ----------------------------------------------------------------------------
// ad7895_emulator_if
// Serial ADC link between the ADC SPI master and the AD7895 responder.
//   CONVST : master -> ADC, falling edge starts a conversion (async to clk)
//   SCLK   : master -> ADC, serial clock (async to clk)
//   BUSY   : ADC -> master, high while converting
//   SDAT   : ADC -> master, serial data, valid for the SCLK rising edge
// ----------------------------------------------------------------------------
interface ad7895_emulator_if;
    logic CONVST;
    logic SCLK;
    logic BUSY;
    logic SDAT;

    modport master (
        output CONVST,
        output SCLK,
        input  BUSY,
        input  SDAT
    );

    modport slave (
        input  CONVST,
        input  SCLK,
        output BUSY,
        output SDAT
    );
endinterface

// File: rtl/ad7895_emulator.sv
// ----------------------------------------------------------------------------
// ad7895_emulator
// Responder-side model of the AD7895 12-bit serial ADC. A CONVST fall samples
// ain, BUSY stays high for CONV_CYCLES clocks, then a FRAME_BITS frame
// (leading zeros + 12 data bits) is shifted out MSB-first on SDAT, one bit
// per SCLK falling edge.
// Ports:
//   clk      : system clock, all logic on posedge
//   rst_n    : synchronous active-low reset
//   bus      : CONVST/SCLK in, BUSY/SDAT out (slave modport)
//   ain      : 12-bit value to be "converted"
//   smp_dat  : last sampled ain (debug)
//   bit_cnt  : SCLK falling edges counted in the current frame (debug)
//   done     : one-clk pulse when a frame completes
// ----------------------------------------------------------------------------
module ad7895_emulator #(
    parameter int unsigned CONV_CYCLES = 100,
    parameter int unsigned FRAME_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ad7895_emulator_if.slave      bus,
    input  logic [11:0]           ain,
    output logic [11:0]           smp_dat,
    output logic [4:0]            bit_cnt,
    output logic                  done
);

    localparam int unsigned CW = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;
    localparam logic [1:0] ST_SHIFT   = 2'd3;

    logic [1:0]            r_state;
    logic                  r_cv_s1, r_cv_s2, r_cv_s3;
    logic                  r_sc_s1, r_sc_s2, r_sc_s3;
    logic                  r_armed;
    logic                  r_busy;
    logic                  r_sdat;
    logic                  r_done;
    logic [11:0]           r_smp;
    logic [4:0]            r_bit_cnt;
    logic [CW-1:0]         r_conv_cnt;
    logic [FRAME_BITS-1:0] r_frame_sr;

    logic w_conv_fall;
    logic w_sclk_fall;
    logic w_conv_start;

    assign w_conv_fall  = r_cv_s3 & ~r_cv_s2;
    assign w_sclk_fall  = r_sc_s3 & ~r_sc_s2;
    // A CONVST that was already low across reset release must not count as
    // a fall: detection is armed only after CONVST has been seen high.
    assign w_conv_start = w_conv_fall & r_armed & (r_state != ST_CONVERT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cv_s1    <= 1'b0;
            r_cv_s2    <= 1'b1;
            r_cv_s3    <= 1'b1;
            r_sc_s1    <= 1'b0;
            r_sc_s2    <= 1'b0;
            r_sc_s3    <= 1'b0;
            r_armed    <= 1'b0;
            r_busy     <= 1'b0;
            r_sdat     <= 1'b0;
            r_done     <= 1'b0;
            r_smp      <= '0;
            r_bit_cnt  <= '0;
            r_conv_cnt <= '0;
            r_frame_sr <= '0;
        end else begin
            r_cv_s1 <= bus.CONVST;
            r_cv_s2 <= r_cv_s1;
            r_cv_s3 <= r_cv_s2;
            r_sc_s1 <= bus.SCLK;
            r_sc_s2 <= r_sc_s1;
            r_sc_s3 <= r_sc_s2;
            r_armed <= r_armed | r_cv_s1;
            r_done  <= 1'b0;

            if (w_conv_start) begin
                // Accepted from IDLE, READY or SHIFT; a running frame is aborted.
                r_state    <= ST_CONVERT;
                r_busy     <= 1'b1;
                r_sdat     <= 1'b0;
                r_smp      <= ain;
                r_frame_sr <= {{(FRAME_BITS-12){1'b0}}, ain};
                r_conv_cnt <= '0;
                r_bit_cnt  <= '0;
            end else begin
                case (r_state)
                    ST_CONVERT: begin
                        if (r_conv_cnt == CW'(CONV_CYCLES - 1)) begin
                            r_state <= ST_READY;
                            r_busy  <= 1'b0;
                            r_sdat  <= r_frame_sr[FRAME_BITS-1];
                        end else begin
                            r_conv_cnt <= r_conv_cnt + CW'(1);
                        end
                    end
                    ST_READY, ST_SHIFT: begin
                        if (w_sclk_fall) begin
                            r_frame_sr <= r_frame_sr << 1;
                            r_bit_cnt  <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'(FRAME_BITS - 1)) begin
                                r_state <= ST_IDLE;
                                r_sdat  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_SHIFT;
                                r_sdat  <= r_frame_sr[FRAME_BITS-2];
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.BUSY = r_busy;
    assign bus.SDAT = r_sdat;
    assign smp_dat  = r_smp;
    assign bit_cnt  = r_bit_cnt;
    assign done     = r_done;

endmodule

// File: doc/ad7895_emulator.md
# ad7895_emulator

Synthesizable model of the AD7895 12-bit serial ADC: the responder side of the CONVST/BUSY/SCLK/SDAT interface driven by our ADC SPI master. It samples a parallel 12-bit test value when CONVST falls and holds BUSY high for a programmable conversion time. It then shifts out a 16-bit frame MSB-first on SDAT: 4 leading zeros followed by the 12 data bits. It sits in the lab top level in place of the real chip, for loopback bring-up and closed-loop simulation of the master.

## Interface
- CONV_CYCLES, 100: BUSY-high duration in clk cycles (≥2).
- FRAME_BITS, 16: bits per frame; fixed frame format is 4 zeros + 12 data bits.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- CONVST  in  1  conversion start from the master; asynchronous to clk; falling edge starts a conversion.
- SCLK  in  1  serial clock from the master; asynchronous; the master samples SDAT on the SCLK rising edge.
- ain  in  12  value to be "converted"; sampled at the detected CONVST fall.
- BUSY  out  1  high while converting.
- SDAT  out  1  serial data, registered.
- smp_dat  out  12  last sampled ain (debug).
- bit_cnt  out  5  SCLK falling edges counted in the current frame (debug).
- done  out  1  one-clk pulse when a frame completes.

## Operation
- Input conditioning:
  - CONVST and SCLK each pass through a 3-flop chain (s1→s2→s3); s2/s3 reset to 1 for CONVST and 0 for SCLK.
  - conv_fall = s3 & !s2 (CONVST chain).
  - sclk_fall = s3 & !s2 (SCLK chain).
- State machine, IDLE / CONVERT / READY / SHIFT; reset state is IDLE.
- IDLE:
  - BUSY=0, SDAT=0.
  - SCLK edges are ignored.
  - conv_fall → CONVERT.
- On every accepted conv_fall:
  - smp_dat←ain, frame_sr←{4'b0, ain}.
  - conv counter←0, bit_cnt←0.
- CONVERT:
  - BUSY=1; the conv counter increments each clk.
  - When the counter reaches CONV_CYCLES-1 → READY: BUSY=0, SDAT←frame_sr[15] (=0).
  - conv_fall during CONVERT is ignored; smp_dat is not re-sampled.
  - SCLK edges are ignored.
- READY and SHIFT:
  - Each sclk_fall: frame_sr←frame_sr<<1, SDAT←new frame_sr[15], bit_cnt+1, state SHIFT.
  - The sclk_fall that makes bit_cnt=16: → IDLE, SDAT←0, done=1 for one clk. bit_cnt holds 16 until the next accepted conv_fall.
- conv_fall in READY or SHIFT aborts the frame and restarts: → CONVERT with a fresh sample, same as from IDLE.
- SCLK rising edges cause no action.
- The master therefore sees data bit k on rising edge k+1 (k=0..15).
- rst_n=0 at any clk edge, including mid-conversion or mid-frame:
  - Next state IDLE; BUSY=0, SDAT=0, smp_dat=0, bit_cnt=0, done=0.
  - Synchronizers return to their reset values.
  - A CONVST already low when reset releases does not start a conversion; a new falling edge is required.

## Timing
- CONVST→BUSY: CONVST first sampled low at posedge N → BUSY=1 after posedge N+2.
- BUSY is high for exactly CONV_CYCLES clk cycles.
- BUSY falls and SDAT shows frame bit 15 on the same posedge.
- SCLK falling edge first sampled at posedge M → SDAT updated after posedge M+2.
- Required SCLK high and low phases: ≥4 clk each, so SDAT settles before the next rising edge. The master's 160 ns SCLK at 50 MHz satisfies this.
- done asserts together with the SDAT←0 update on the 16th falling edge.
- CONVST low pulse must be ≥2 clk to be detected.

## Test plan
- Reset: hold rst_n=0 for 5 clk with CONVST=0 and SCLK toggling → BUSY=0, SDAT=0, smp_dat=0, bit_cnt=0, done=0. Release with CONVST still low → no BUSY.
- Basic frame: ain=12'hA5C, CONV_CYCLES=100, CONVST low 4 clk, then 16 SCLK periods of 8 clk after BUSY falls.
  - BUSY rises at the 3rd posedge after CONVST low and stays high exactly 100 clk.
  - Bits captured on SCLK rises = 16'h0A5C.
  - done pulses once; bit_cnt=16.
- Extremes: ain=12'hFFF → captured 16'h0FFF; ain=12'h000 → 16'h0000. Change ain during CONVERT → captured value is unchanged.
- Retrigger during CONVERT: second CONVST fall 20 clk into BUSY with ain changed to 12'h123 → BUSY width still 100 clk; first value transmitted.
- Abort mid-frame: after 7 SCLK falls, CONVST fall with ain=12'h3C3 → BUSY reasserts, bit_cnt=0, no done. Next full frame reads 16'h03C3.
- Extra edges: 20 SCLK periods after BUSY falls → first 16 rises capture the frame, remaining rises read 0, done pulses exactly once. SCLK toggling while BUSY=1 → SDAT stays 0 and bit_cnt stays 0.
